// File: rtl/tlb_csr_pkg.sv
// Shared constants for the TLBIDX CSR: field positions, reset value and the
// fill-index LFSR seed/taps.
package tlb_csr_pkg;

  localparam int unsigned TLBIDX_PS_LSB = 24;
  localparam int unsigned TLBIDX_PS_W   = 6;
  localparam int unsigned TLBIDX_NE_BIT = 31;

  localparam logic [31:0] TLBIDX_RST = 32'h8000_0000;

  // Fibonacci LFSR x^8+x^6+x^5+x^4+1, shifting left: feedback is the XOR of
  // state bits 7,5,4,3.
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/tlb_fill_idx_gen.sv
// Victim-index generator for TLBFILL.
// Default build: round-robin counter, resets to 0, +1 per adv, wraps naturally.
// With TLBIDX_FILL_LFSR_EN defined: 8-bit Fibonacci LFSR seeded from the
// package, idx = low IDX_W bits of the LFSR state.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   adv        : advance the generator (TLBFILL consumed idx this cycle)
//   idx        : registered victim index, valid every cycle
module tlb_fill_idx_gen
  import tlb_csr_pkg::*;
#(
  parameter int unsigned IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  output logic [IDX_W-1:0] idx
);

`ifdef TLBIDX_FILL_LFSR_EN
  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (adv) lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign idx = lfsr_q[IDX_W-1:0];
`else
  logic [IDX_W-1:0] cnt_q, cnt_d;

  // TLB_ENTRIES is a power of two, so the IDX_W-bit add wraps at the top.
  always_comb begin
    cnt_d = cnt_q;
    if (adv) cnt_d = cnt_q + {{(IDX_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign idx = cnt_q;
`endif

endmodule

// File: rtl/tlbidx_csr_unit.sv
// TLBIDX CSR for the LoongArch32 system-register block.
// Holds INDEX/PS/NE, tracks an outstanding TLBSRCH, and owns the TLBFILL
// victim-index generator. Build macro: TLBIDX_FILL_LFSR_EN selects the LFSR
// fill generator instead of the round-robin counter.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   csr_we, csr_wdata           : CSR write to TLBIDX
//   srch_req, srch_busy         : search launch / search outstanding
//   srch_rsp_valid, srch_hit,
//   srch_hit_idx                : search result (1-cycle pulse)
//   tlbrd_en, tlbrd_ps, tlbrd_e : TLBRD completion with entry PS/E
//   tlbfill_en, fill_idx        : TLBFILL consume strobe / victim index
//   tlbidx                      : architectural TLBIDX value (registered fields)
module tlbidx_csr_unit
  import tlb_csr_pkg::*;
#(
  parameter int unsigned TLB_ENTRIES = 16,
  parameter int unsigned IDX_W       = $clog2(TLB_ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             csr_we,
  input  logic [31:0]      csr_wdata,
  input  logic             srch_req,
  output logic             srch_busy,
  input  logic             srch_rsp_valid,
  input  logic             srch_hit,
  input  logic [IDX_W-1:0] srch_hit_idx,
  input  logic             tlbrd_en,
  input  logic [5:0]       tlbrd_ps,
  input  logic             tlbrd_e,
  input  logic             tlbfill_en,
  output logic [IDX_W-1:0] fill_idx,
  output logic [31:0]      tlbidx
);

  logic [IDX_W-1:0]       index_q, index_d;
  logic [TLBIDX_PS_W-1:0] ps_q, ps_d;
  logic                   ne_q, ne_d;
  logic                   busy_q, busy_d;
  logic                   rsp_fire;

  // Responses arriving with no search outstanding are dropped.
  assign rsp_fire = srch_rsp_valid & busy_q;

  // Per-field priority: later assignments win (TLBRD > search > CSR write).
  always_comb begin
    index_d = index_q;
    ps_d    = ps_q;
    ne_d    = ne_q;
    if (csr_we) begin
      index_d = csr_wdata[IDX_W-1:0];
      ps_d    = csr_wdata[TLBIDX_PS_LSB +: TLBIDX_PS_W];
      ne_d    = csr_wdata[TLBIDX_NE_BIT];
    end
    if (rsp_fire) begin
      if (srch_hit) index_d = srch_hit_idx;
      ne_d = ~srch_hit;
    end
    if (tlbrd_en) begin
      ps_d = tlbrd_ps;
      ne_d = ~tlbrd_e;
    end
  end

  // A request arriving alongside the completing response is dropped.
  always_comb begin
    busy_d = busy_q;
    if (busy_q) begin
      if (srch_rsp_valid) busy_d = 1'b0;
    end else if (srch_req) begin
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index_q <= TLBIDX_RST[IDX_W-1:0];
      ps_q    <= TLBIDX_RST[TLBIDX_PS_LSB +: TLBIDX_PS_W];
      ne_q    <= TLBIDX_RST[TLBIDX_NE_BIT];
      busy_q  <= 1'b0;
    end else begin
      index_q <= index_d;
      ps_q    <= ps_d;
      ne_q    <= ne_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    tlbidx                                      = '0;
    tlbidx[IDX_W-1:0]                           = index_q;
    tlbidx[TLBIDX_PS_LSB +: TLBIDX_PS_W]        = ps_q;
    tlbidx[TLBIDX_NE_BIT]                       = ne_q;
  end

  assign srch_busy = busy_q;

  // Reserved write-data bits are discarded.
  logic unused_wdata;
  assign unused_wdata = ^{csr_wdata[TLBIDX_NE_BIT-1], csr_wdata[TLBIDX_PS_LSB-1:IDX_W]};

  tlb_fill_idx_gen #(
    .IDX_W (IDX_W)
  ) u_fill_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (tlbfill_en),
    .idx   (fill_idx)
  );

endmodule

// File: tb/tb_tlbidx_csr_unit.sv
module tb_tlbidx_csr_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        csr_we;
  logic [31:0] csr_wdata;
  logic        srch_req;
  logic        srch_busy;
  logic        srch_rsp_valid;
  logic        srch_hit;
  logic [3:0]  srch_hit_idx;
  logic        tlbrd_en;
  logic [5:0]  tlbrd_ps;
  logic        tlbrd_e;
  logic        tlbfill_en;
  logic [3:0]  fill_idx;
  logic [31:0] tlbidx;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tlbidx_csr_unit #(
    .TLB_ENTRIES (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .csr_we         (csr_we),
    .csr_wdata      (csr_wdata),
    .srch_req       (srch_req),
    .srch_busy      (srch_busy),
    .srch_rsp_valid (srch_rsp_valid),
    .srch_hit       (srch_hit),
    .srch_hit_idx   (srch_hit_idx),
    .tlbrd_en       (tlbrd_en),
    .tlbrd_ps       (tlbrd_ps),
    .tlbrd_e        (tlbrd_e),
    .tlbfill_en     (tlbfill_en),
    .fill_idx       (fill_idx),
    .tlbidx         (tlbidx)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    csr_we = 0; csr_wdata = '0; srch_req = 0; srch_rsp_valid = 0; srch_hit = 0;
    srch_hit_idx = '0; tlbrd_en = 0; tlbrd_ps = '0; tlbrd_e = 0; tlbfill_en = 0;
  endtask

  task automatic test_reset();
    logic [3:0] exp_fill;
`ifdef TLBIDX_FILL_LFSR_EN
    exp_fill = 4'h5;
`else
    exp_fill = 4'h0;
`endif
    idle_inputs();
    rst_n = 0;
    step(); step();
    total++;
    if (tlbidx !== 32'h8000_0000) begin
      bad++; $display("FAIL reset_tlbidx got=%h exp=%h", tlbidx, 32'h8000_0000);
    end
    total++;
    if (srch_busy !== 1'b0) begin
      bad++; $display("FAIL reset_busy got=%b exp=0", srch_busy);
    end
    total++;
    if (fill_idx !== exp_fill) begin
      bad++; $display("FAIL reset_fill got=%h exp=%h", fill_idx, exp_fill);
    end
    rst_n = 1;
    step();
  endtask

  task automatic test_csr_write();
    csr_we = 1; csr_wdata = 32'hBFFF_FFFF;
    step();
    idle_inputs();
    total++;
    if (tlbidx !== 32'hBF00_000F) begin
      bad++; $display("FAIL csr_write got=%h exp=%h", tlbidx, 32'hBF00_000F);
    end
  endtask

  task automatic test_search_hit();
    srch_req = 1;
    step();
    srch_req = 0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (srch_busy !== 1'b1) begin
        bad++; $display("FAIL hit_busy_cyc%0d got=%b exp=1", i, srch_busy);
      end
      if (i < 3) step();
    end
    srch_rsp_valid = 1; srch_hit = 1; srch_hit_idx = 4'h9;
    step();
    idle_inputs();
    total++;
    if (srch_busy !== 1'b0) begin
      bad++; $display("FAIL hit_busy_clear got=%b exp=0", srch_busy);
    end
    total++;
    if (tlbidx !== 32'h3F00_0009) begin
      bad++; $display("FAIL hit_tlbidx got=%h exp=%h", tlbidx, 32'h3F00_0009);
    end
  endtask

  task automatic test_search_miss();
    srch_req = 1;
    step();
    srch_req = 0;
    srch_rsp_valid = 1; srch_hit = 0; srch_hit_idx = 4'h4;
    step();
    idle_inputs();
    total++;
    if (tlbidx !== 32'hBF00_0009) begin
      bad++; $display("FAIL miss_tlbidx got=%h exp=%h", tlbidx, 32'hBF00_0009);
    end
    // Stray response while idle must change nothing.
    srch_rsp_valid = 1; srch_hit = 1; srch_hit_idx = 4'h3;
    step();
    idle_inputs();
    total++;
    if (tlbidx !== 32'hBF00_0009) begin
      bad++; $display("FAIL idle_rsp_tlbidx got=%h exp=%h", tlbidx, 32'hBF00_0009);
    end
    total++;
    if (srch_busy !== 1'b0) begin
      bad++; $display("FAIL idle_rsp_busy got=%b exp=0", srch_busy);
    end
  endtask

  task automatic test_priority();
    srch_req = 1;
    step();
    srch_req = 0;
    tlbrd_en = 1; tlbrd_ps = 6'h0C; tlbrd_e = 1;
    srch_rsp_valid = 1; srch_hit = 1; srch_hit_idx = 4'h2;
    csr_we = 1; csr_wdata = 32'h8500_0007;
    step();
    idle_inputs();
    total++;
    if (tlbidx !== 32'h0C00_0002) begin
      bad++; $display("FAIL priority_tlbidx got=%h exp=%h", tlbidx, 32'h0C00_0002);
    end
    // csr_we alone with a hit: INDEX/NE from search, PS from csr_wdata.
    srch_req = 1;
    step();
    srch_req = 0;
    srch_rsp_valid = 1; srch_hit = 1; srch_hit_idx = 4'hB;
    csr_we = 1; csr_wdata = 32'h9500_0004;
    step();
    idle_inputs();
    total++;
    if (tlbidx !== 32'h1500_000B) begin
      bad++; $display("FAIL csr_vs_hit got=%h exp=%h", tlbidx, 32'h1500_000B);
    end
  endtask

  task automatic test_back_to_back();
    srch_req = 1;
    step();
    // Response plus a new request: the request is dropped.
    srch_req = 1; srch_rsp_valid = 1; srch_hit = 0;
    step();
    idle_inputs();
    total++;
    if (srch_busy !== 1'b0) begin
      bad++; $display("FAIL b2b_busy got=%b exp=0", srch_busy);
    end
    total++;
    if (tlbidx !== 32'h9500_000B) begin
      bad++; $display("FAIL b2b_tlbidx got=%h exp=%h", tlbidx, 32'h9500_000B);
    end
  endtask

  task automatic test_fill();
`ifdef TLBIDX_FILL_LFSR_EN
    logic [7:0] m;
    logic [3:0] seen [0:299];
    m = 8'hA5;
    tlbfill_en = 1;
    for (int i = 0; i < 300; i++) begin
      step();
      m = {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
      seen[i] = fill_idx;
      total++;
      if (fill_idx !== m[3:0]) begin
        bad++; $display("FAIL lfsr_step%0d got=%h exp=%h", i, fill_idx, m[3:0]);
      end
    end
    tlbfill_en = 0;
    total++;
    if (seen[280] !== seen[25]) begin
      bad++; $display("FAIL lfsr_period got=%h exp=%h", seen[280], seen[25]);
    end
`else
    for (int i = 0; i < 18; i++) begin
      logic [3:0] exp_idx;
      exp_idx = 4'(i % 16);
      total++;
      if (fill_idx !== exp_idx) begin
        bad++; $display("FAIL rr_fill%0d got=%h exp=%h", i, fill_idx, exp_idx);
      end
      if (i < 17) begin
        tlbfill_en = 1;
        step();
        tlbfill_en = 0;
      end
    end
    // No advance without a strobe.
    step();
    total++;
    if (fill_idx !== 4'h1) begin
      bad++; $display("FAIL rr_hold got=%h exp=1", fill_idx);
    end
`endif
  endtask

  task automatic test_reset_midsearch();
    srch_req = 1;
    step();
    srch_req = 0;
    total++;
    if (srch_busy !== 1'b1) begin
      bad++; $display("FAIL midrst_busy_pre got=%b exp=1", srch_busy);
    end
    rst_n = 0;
    #2;
    total++;
    if (srch_busy !== 1'b0) begin
      bad++; $display("FAIL midrst_busy_async got=%b exp=0", srch_busy);
    end
    step();
    rst_n = 1;
    step();
    srch_rsp_valid = 1; srch_hit = 1; srch_hit_idx = 4'h7;
    step();
    idle_inputs();
    total++;
    if (srch_busy !== 1'b0) begin
      bad++; $display("FAIL midrst_busy_post got=%b exp=0", srch_busy);
    end
    total++;
    if (tlbidx !== 32'h8000_0000) begin
      bad++; $display("FAIL midrst_tlbidx got=%h exp=%h", tlbidx, 32'h8000_0000);
    end
  endtask

  initial begin
    test_reset();
    test_csr_write();
    test_search_hit();
    test_search_miss();
    test_priority();
    test_back_to_back();
    test_fill();
    test_reset_midsearch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tlbidx_csr_unit.md
Name: tlbidx_csr_unit

Overview:
- Parametrised next-generation TLBIDX CSR for the LoongArch32 core's system-register block.
- Holds the INDEX, PS and NE fields. TLB depth is set by parameter.
- Tracks a multi-cycle TLBSRCH with a busy/response handshake.
- Owns the fill-index generator that TLBFILL uses to pick its victim entry.

Parameters:
- TLB_ENTRIES, 16, number of TLB entries; power of 2, range 4..64.
- IDX_W, $clog2(TLB_ENTRIES), INDEX field width; derived, never overridden.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- csr_we  in  1  CSRWR/CSRXCHG write strobe to TLBIDX
- csr_wdata  in  32  write data
- srch_req  in  1  TLBSRCH issued; launches a search
- srch_busy  out  1  search outstanding
- srch_rsp_valid  in  1  search result valid, 1-cycle pulse
- srch_hit  in  1  search hit
- srch_hit_idx  in  IDX_W  index of the hit entry
- tlbrd_en  in  1  TLBRD completes this cycle
- tlbrd_ps  in  6  PS of the entry read
- tlbrd_e  in  1  E bit of the entry read
- tlbfill_en  in  1  TLBFILL consumes fill_idx this cycle
- fill_idx  out  IDX_W  victim index for the next TLBFILL
- tlbidx  out  32  architectural TLBIDX value, registered

Behaviour:
- Field layout:
  - INDEX = [IDX_W-1:0]
  - PS = [29:24]
  - NE = [31]
  - All other bits are held 0; writes to them are discarded.
- Reset: tlbidx = 32'h8000_0000, srch_busy = 0, fill_idx = reset value of the generator.
- CSR write (csr_we): INDEX, PS and NE load from csr_wdata on the next edge. Only bits [IDX_W-1:0] of INDEX are kept.
- Search handshake:
  - srch_req while idle sets srch_busy on the next edge.
  - srch_req while busy is ignored; the issue stage must not send it.
  - srch_rsp_valid while busy clears srch_busy.
    - On hit: INDEX <= srch_hit_idx, NE <= 0.
    - On miss: NE <= 1, INDEX unchanged.
  - srch_rsp_valid while idle is ignored and changes no state.
  - srch_req and srch_rsp_valid in the same cycle while busy: the response completes and the new request is dropped (busy = 0).
  - Minimum request-to-response latency is 1 cycle. No upper bound.
- TLBRD (tlbrd_en): PS <= tlbrd_ps, NE <= ~tlbrd_e. INDEX unchanged.
- Simultaneous updates resolve per field in priority order: TLBRD > search response > csr_we.
  - Example: csr_we together with a search hit gives INDEX and NE from the search and PS from csr_wdata.
- Fill generator (round-robin, default build):
  - fill_idx resets to 0 and increments on each tlbfill_en.
  - Wraps from TLB_ENTRIES-1 to 0.
  - fill_idx is registered and valid every cycle.
- A reset asserted mid-search clears srch_busy. Any later srch_rsp_valid is then ignored.
- tlbidx has no combinational path from any input.

Optional Feature:
- TLBIDX_FILL_LFSR_EN defined:
  - Fill generator is an 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, seed 8'hA5.
  - Advances once per tlbfill_en.
  - fill_idx = LFSR[IDX_W-1:0], so the reset value is 8'hA5 truncated to IDX_W bits.
- Undefined: round-robin counter as specified in Behaviour.

Decomposition:
- Package tlb_csr_pkg holds:
  - field positions: TLBIDX_PS_LSB = 24, TLBIDX_PS_W = 6, TLBIDX_NE_BIT = 31
  - reset constant TLBIDX_RST = 32'h8000_0000
  - LFSR seed and taps
- Sub-module tlb_fill_idx_gen (params IDX_W; ports clk, rst_n, adv, idx) contains both generator variants, selected by the macro.

Test Plan:
- Reset, then csr_we with 32'hBFFF_FFFF (TLB_ENTRIES = 16) -> tlbidx = 32'hBF00_000F.
- srch_req, then 3 idle cycles, then srch_rsp_valid with hit = 1, idx = 4'h9 -> busy high for 4 cycles, then tlbidx[3:0] = 9 and NE = 0.
- Follow with a search that misses -> NE = 1, INDEX still 9. Then a lone srch_rsp_valid while idle -> no change.
- Same cycle: tlbrd_en with ps = 6'h0C, e = 1, a search hit with idx = 2, and csr_we with 32'h8500_0007 -> PS = 0x0C, NE = 0, INDEX = 2.
- Round-robin build: 17 tlbfill_en pulses -> fill_idx sequence 0, 1, …, 15, 0, 1.
- TLBIDX_FILL_LFSR_EN build: fill_idx at reset = 4'h5. Check against a reference-model LFSR over 300 advances; sequence repeats every 255.
- Assert rst_n low while busy, then pulse srch_rsp_valid after release -> busy = 0, tlbidx = 32'h8000_0000.
